// File: rtl/parking_slot_allocator_pkg.sv
// Shared definitions for the parking slot allocator.
// Holds the FSM encodings, default sizes and the gate counter type.
package parking_slot_allocator_pkg;

    localparam int DEF_N_SLOTS     = 3;
    localparam int DEF_GATE_CYCLES = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GATE = 1'b1;

    typedef logic [3:0] gate_cnt_t;

endpackage

// File: rtl/parking_slot_allocator_free_slot_encoder.sv
// Lowest-index empty slot finder for the parking allocator.
// Purely combinational; any_free is low when every slot is taken.
module free_slot_encoder
    import parking_slot_allocator_pkg::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS
) (
    input  logic [N_SLOTS-1:0] parked,
    output logic [1:0]         index,
    output logic               any_free
);

    // Scan high to low so the last hit is the lowest free slot.
    always_comb begin
        index    = '0;
        any_free = 1'b0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!parked[i]) begin
                index    = 2'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_slot_allocator.sv
// Parking lot slot allocator with entry/exit handshakes and a timed gate.
// Exit requests win over entry; requests are only looked at while idle.
module parking_slot_allocator
    import parking_slot_allocator_pkg::*;
#(
    parameter int N_SLOTS     = DEF_N_SLOTS,
    parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               entry_req,
    input  logic               exit_req,
    input  logic [1:0]         exit_slot,
    output logic               entry_ack,
    output logic               entry_deny,
    output logic               exit_ack,
    output logic               exit_err,
    output logic [1:0]         slot_id,
    output logic [N_SLOTS-1:0] parked,
    output logic [1:0]         empty_count,
    output logic               full,
    output logic               gate_open
);

    logic [0:0]         state_q, state_d;
    logic [N_SLOTS-1:0] parked_q, parked_d;
    logic [1:0]         slot_id_q, slot_id_d;
    gate_cnt_t          cnt_q, cnt_d;
    logic               gate_q, gate_d;
    logic               entry_ack_q, entry_ack_d;
    logic               entry_deny_q, entry_deny_d;
    logic               exit_ack_q, exit_ack_d;
    logic               exit_err_q, exit_err_d;

    logic [1:0] free_idx;
    logic       any_free;
    logic       exit_hit;

    free_slot_encoder #(
        .N_SLOTS (N_SLOTS)
    ) u_enc (
        .parked   (parked_q),
        .index    (free_idx),
        .any_free (any_free)
    );

    // Out-of-range slot indices never match, so they land in exit_err.
    always_comb begin
        exit_hit = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (exit_slot == 2'(i)) begin
                exit_hit = parked_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        parked_d     = parked_q;
        slot_id_d    = slot_id_q;
        cnt_d        = cnt_q;
        gate_d       = gate_q;
        entry_ack_d  = 1'b0;
        entry_deny_d = 1'b0;
        exit_ack_d   = 1'b0;
        exit_err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (exit_req) begin
                    if (exit_hit) begin
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (exit_slot == 2'(i)) begin
                                parked_d[i] = 1'b0;
                            end
                        end
                        exit_ack_d = 1'b1;
                        gate_d     = 1'b1;
                        cnt_d      = gate_cnt_t'(GATE_CYCLES - 1);
                        state_d    = ST_GATE;
                    end else begin
                        exit_err_d = 1'b1;
                    end
                end else if (entry_req) begin
                    if (any_free) begin
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (free_idx == 2'(i)) begin
                                parked_d[i] = 1'b1;
                            end
                        end
                        slot_id_d   = free_idx;
                        entry_ack_d = 1'b1;
                        gate_d      = 1'b1;
                        cnt_d       = gate_cnt_t'(GATE_CYCLES - 1);
                        state_d     = ST_GATE;
                    end else begin
                        entry_deny_d = 1'b1;
                    end
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    gate_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - gate_cnt_t'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            parked_q     <= '0;
            slot_id_q    <= '0;
            cnt_q        <= '0;
            gate_q       <= 1'b0;
            entry_ack_q  <= 1'b0;
            entry_deny_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            parked_q     <= parked_d;
            slot_id_q    <= slot_id_d;
            cnt_q        <= cnt_d;
            gate_q       <= gate_d;
            entry_ack_q  <= entry_ack_d;
            entry_deny_q <= entry_deny_d;
            exit_ack_q   <= exit_ack_d;
            exit_err_q   <= exit_err_d;
        end
    end

    always_comb begin
        empty_count = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!parked_q[i]) begin
                empty_count = empty_count + 2'd1;
            end
        end
    end

    assign full       = &parked_q;
    assign parked     = parked_q;
    assign slot_id    = slot_id_q;
    assign gate_open  = gate_q;
    assign entry_ack  = entry_ack_q;
    assign entry_deny = entry_deny_q;
    assign exit_ack   = exit_ack_q;
    assign exit_err   = exit_err_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Scoreboard bench for parking_slot_allocator.
// A high-level lot model predicts every pulse; a monitor checks them.
module tb_parking_slot_allocator;

    localparam int NS = 3;
    localparam int GC = 4;

    localparam int K_EACK = 0;
    localparam int K_DENY = 1;
    localparam int K_XACK = 2;
    localparam int K_XERR = 3;

    typedef struct {
        int       kind;
        logic [2:0] occ;
        int       slot;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic       entry_ack, entry_deny, exit_ack, exit_err;
    logic [1:0] slot_id;
    logic [2:0] parked;
    logic [1:0] empty_count;
    logic       full;
    logic       gate_open;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    // Behavioural lot: one bool per slot plus the last granted slot.
    bit lot[NS];
    int last_slot = 0;
    int gate_run = 0;

    always #5 clk = ~clk;

    parking_slot_allocator #(
        .N_SLOTS     (NS),
        .GATE_CYCLES (GC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .exit_slot   (exit_slot),
        .entry_ack   (entry_ack),
        .entry_deny  (entry_deny),
        .exit_ack    (exit_ack),
        .exit_err    (exit_err),
        .slot_id     (slot_id),
        .parked      (parked),
        .empty_count (empty_count),
        .full        (full),
        .gate_open   (gate_open)
    );

    function automatic logic [2:0] lot_vec();
        logic [2:0] v;
        for (int i = 0; i < NS; i++) v[i] = lot[i];
        return v;
    endfunction

    function automatic int lot_free();
        int n = 0;
        for (int i = 0; i < NS; i++) if (!lot[i]) n++;
        return n;
    endfunction

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void model_entry();
        exp_t e;
        int k = -1;
        for (int i = NS - 1; i >= 0; i--) if (!lot[i]) k = i;
        if (k < 0) begin
            e.kind = K_DENY;
        end else begin
            lot[k] = 1'b1;
            last_slot = k;
            e.kind = K_EACK;
        end
        e.occ = lot_vec();
        e.slot = last_slot;
        exp_q.push_back(e);
    endfunction

    function automatic void model_exit(int s);
        exp_t e;
        if (s < NS && lot[s]) begin
            lot[s] = 1'b0;
            e.kind = K_XACK;
        end else begin
            e.kind = K_XERR;
        end
        e.occ = lot_vec();
        e.slot = last_slot;
        exp_q.push_back(e);
    endfunction

    task automatic wait_pulse(string who);
        bit seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (entry_ack | entry_deny | exit_ack | exit_err) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout %s: got no pulse expected one", who);
        end
    endtask

    task automatic do_entry();
        model_entry();
        entry_req = 1'b1;
        wait_pulse("entry");
        entry_req = 1'b0;
    endtask

    task automatic do_exit(int s);
        model_exit(s);
        exit_slot = 2'(s);
        exit_req = 1'b1;
        wait_pulse("exit");
        exit_req = 1'b0;
    endtask

    task automatic do_both(int s);
        model_exit(s);
        model_entry();
        exit_slot = 2'(s);
        exit_req = 1'b1;
        entry_req = 1'b1;
        wait_pulse("both_exit");
        exit_req = 1'b0;
        wait_pulse("both_entry");
        entry_req = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops one prediction per pulse and tracks gate length.
    always @(negedge clk) begin
        if (!rst_n) begin
            gate_run = 0;
        end else begin
            if (entry_ack | entry_deny | exit_ack | exit_err) begin
                exp_t e;
                int kind;
                check("pulse_onehot",
                      int'($onehot({entry_ack, entry_deny, exit_ack, exit_err})), 1);
                kind = entry_ack ? K_EACK : entry_deny ? K_DENY :
                       exit_ack ? K_XACK : K_XERR;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("parked", int'(parked), int'(e.occ));
                    check("slot_id", int'(slot_id), e.slot);
                    check("empty_count", int'(empty_count),
                          NS - $countones(e.occ));
                    check("full", int'(full), int'(e.occ == 3'b111));
                    check("gate_at_pulse", int'(gate_open),
                          int'(e.kind == K_EACK || e.kind == K_XACK));
                end
            end
            if (gate_open) begin
                gate_run++;
            end else if (gate_run != 0) begin
                check("gate_len", gate_run, GC);
                gate_run = 0;
            end
        end
    end

    initial begin
        int op;
        for (int i = 0; i < NS; i++) lot[i] = 1'b0;
        #1;
        check("rst_parked", int'(parked), 0);
        check("rst_empty", int'(empty_count), NS);
        check("rst_full", int'(full), 0);
        check("rst_gate", int'(gate_open), 0);
        check("rst_slot", int'(slot_id), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        do_entry();
        do_entry();
        do_entry();
        idle(6);
        check("full_after_3", int'(full), 1);

        do_entry();
        idle(2);
        check("deny_no_gate", int'(gate_open), 0);

        do_exit(1);
        do_entry();
        do_both(0);
        idle(6);

        do_exit(2);
        idle(6);
        do_exit(2);
        do_exit(3);
        idle(2);

        do_entry();
        idle(2);
        rst_n = 1'b0;
        #1;
        check("midgate_gate", int'(gate_open), 0);
        check("midgate_parked", int'(parked), 0);
        check("midgate_empty", int'(empty_count), NS);
        for (int i = 0; i < NS; i++) lot[i] = 1'b0;
        last_slot = 0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 4));
            if (op < 2) do_entry();
            else if (op < 4) do_exit(int'($urandom_range(0, 3)));
            else do_both(int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 5)));
        end
        idle(8);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
